parking_log_reader: RTL and testbench

//  Read-side controller for the 8x16 dual-port parking log RAM. On a start request it walks the

---
 rtl/parking_log_reader_pkg.sv | 20 ++
 rtl/parking_log_reader_if.sv | 25 ++
 rtl/parking_log_reader_dwell_timer.sv | 21 ++
 rtl/parking_log_reader.sv | 82 ++++++++
 tb/tb_parking_log_reader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_log_reader_pkg.sv
// parking_log_reader_pkg: shared widths, types and FSM encodings for the parking log reader.
package parking_log_reader_pkg;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [ADDR_W:0]   ord_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] PRESENT = 3'd2;
   localparam logic [2:0] DWELL   = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   function automatic ord_t clamp_count(input ord_t c);
      return (c > ord_t'(DEPTH)) ? ord_t'(DEPTH) : c;
   endfunction
endpackage

// File: rtl/parking_log_reader_if.sv
// parking_log_reader_if: control, RAM read port and output stream of the log reader.
interface parking_log_reader_if;
   import parking_log_reader_pkg::*;
   logic  start;
   logic  abort;
   addr_t head;
   ord_t  count;
   addr_t rd_addr;
   data_t rd_data;
   data_t out_data;
   addr_t out_index;
   logic  out_valid;
   logic  out_ready;
   logic  busy;
   logic  done;

   modport master (
      input  start, abort, head, count, rd_data, out_ready,
      output rd_addr, out_data, out_index, out_valid, busy, done
   );
   modport slave (
      output start, abort, head, count, rd_data, out_ready,
      input  rd_addr, out_data, out_index, out_valid, busy, done
   );
endinterface

// File: rtl/parking_log_reader_dwell_timer.sv
// dwell_timer: loadable down-counter that stops at zero.
module dwell_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] val,
   output logic         zero
);
   logic [W-1:0] cnt;

   assign zero = cnt == '0;

   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= val;
      else if (en && !zero) cnt <= cnt - W'(1);
   end
endmodule

// File: rtl/parking_log_reader.sv
// parking_log_reader: walks the valid log entries oldest-first and streams each word
// over valid/ready, with an optional idle gap after every accepted word.
module parking_log_reader
   import parking_log_reader_pkg::*;
#(
   parameter int DWELL_CYCLES = 0
) (
   input logic clk,
   input logic reset,
   parking_log_reader_if.master bus
);
   localparam int TW = DWELL_CYCLES > 0 ? $clog2(DWELL_CYCLES + 1) : 1;
   // Loading one less than the gap makes the zero cycle the last dwell cycle.
   localparam logic [TW-1:0] DW_LOAD = TW'(DWELL_CYCLES > 0 ? DWELL_CYCLES - 1 : 0);

   logic [2:0] state;
   addr_t      rd_addr;
   addr_t      out_index;
   data_t      out_data;
   ord_t       n;
   ord_t       ord;
   ord_t       n_req;
   logic       out_valid;
   logic       accept;
   logic       dw_zero;

   assign n_req         = clamp_count(bus.count);
   assign accept        = state == PRESENT && bus.out_ready;
   assign bus.rd_addr   = rd_addr;
   assign bus.out_data  = out_data;
   assign bus.out_index = out_index;
   assign bus.out_valid = out_valid;
   assign bus.busy      = state != IDLE;
   assign bus.done      = state == DONE;

   dwell_timer #(.W(TW)) u_dwell (
      .clk  (clk),
      .reset(reset),
      .load (accept),
      .en   (state == DWELL),
      .val  (DW_LOAD),
      .zero (dw_zero)
   );

   always_ff @(posedge clk) begin
      if (reset || (bus.abort && state != IDLE)) begin
         state     <= IDLE;
         rd_addr   <= '0;
         out_data  <= '0;
         out_index <= '0;
         out_valid <= 1'b0;
         n         <= '0;
         ord       <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               n       <= n_req;
               ord     <= '0;
               rd_addr <= bus.head - addr_t'(n_req);
               state   <= n_req == '0 ? DONE : FETCH;
            end
            FETCH: begin
               out_data  <= bus.rd_data;
               out_index <= addr_t'(ord);
               out_valid <= 1'b1;
               state     <= PRESENT;
            end
            PRESENT: if (bus.out_ready) begin
               out_valid <= 1'b0;
               if (ord == n - ord_t'(1)) state <= DONE;
               else begin
                  rd_addr <= rd_addr + addr_t'(1);
                  ord     <= ord + ord_t'(1);
                  state   <= DWELL_CYCLES == 0 ? FETCH : DWELL;
               end
            end
            DWELL: if (dw_zero) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_parking_log_reader.sv
// tb_parking_log_reader: two readers (no dwell, dwell of 3) on a shared log RAM, checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_parking_log_reader;
   import parking_log_reader_pkg::*;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   logic  start = 1'b0;
   logic  abort = 1'b0;
   logic  out_ready = 1'b0;
   addr_t head = '0;
   ord_t  count = '0;
   data_t mem [8];

   always #5 clk = ~clk;

   parking_log_reader_if ifc0 ();
   parking_log_reader_if ifc3 ();

   assign ifc0.start     = start;
   assign ifc0.abort     = abort;
   assign ifc0.head      = head;
   assign ifc0.count     = count;
   assign ifc0.out_ready = out_ready;
   assign ifc0.rd_data   = mem[ifc0.rd_addr];
   assign ifc3.start     = start;
   assign ifc3.abort     = abort;
   assign ifc3.head      = head;
   assign ifc3.count     = count;
   assign ifc3.out_ready = out_ready;
   assign ifc3.rd_data   = mem[ifc3.rd_addr];

   parking_log_reader #(.DWELL_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(ifc0.master));
   parking_log_reader #(.DWELL_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(ifc3.master));

   int n_total = 0;
   int n_pass  = 0;

   // Model: one readout is n words from base; the first word appears one edge after the
   // start edge, each later one dw+1 edges after the previous accept.
   int dw   [2] = '{0, 3};
   int gexp [2] = '{1, 4};
   bit m_act [2], m_valid [2], m_done [2], m_zero [2];
   int m_n [2], m_k [2], m_base [2], m_gap [2];

   int log_addr [$];
   int log_data [$];
   int log_idx [$];
   int acc3;
   bit seen [2];
   int low [2], gap_n [2], gap_bad [2], gap_last [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_act[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_gap[i] = 0; m_zero[i] = 1;
         end else if (m_act[i] && (abort || m_done[i])) begin
            m_zero[i] = m_zero[i] | abort;
            m_act[i] = 0; m_valid[i] = 0; m_done[i] = 0; m_gap[i] = 0;
         end else if (!m_act[i]) begin
            if (start) begin
               m_n[i]    = int'(count) > 8 ? 8 : int'(count);
               m_base[i] = (int'(head) + 8 - m_n[i]) % 8;
               m_k[i]    = 0;
               m_act[i]  = 1;
               m_zero[i] = 0;
               if (m_n[i] == 0) m_done[i] = 1;
               else m_gap[i] = 1;
            end
         end else if (m_valid[i]) begin
            if (out_ready) begin
               m_valid[i] = 0;
               m_k[i]++;
               if (m_k[i] == m_n[i]) m_done[i] = 1;
               else m_gap[i] = dw[i] + 1;
            end
         end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0) m_valid[i] = 1;
         end
      end
   endtask

   task automatic cmp(input int i, input logic v, input logic b, input logic d,
                      input addr_t ra, input data_t od, input addr_t oi);
      string p;
      int a;
      p = $sformatf("u%0d", dw[i]);
      chk({p, " out_valid"}, v, m_valid[i]);
      chk({p, " busy"}, b, m_act[i]);
      chk({p, " done"}, d, m_done[i]);
      if (m_valid[i]) begin
         a = (m_base[i] + m_k[i]) % 8;
         chk({p, " rd_addr"}, ra, a);
         chk({p, " out_data"}, od, mem[a]);
         chk({p, " out_index"}, oi, m_k[i]);
      end
      if (m_zero[i]) begin
         chk({p, " rd_addr zero"}, ra, 0);
         chk({p, " out_data zero"}, od, 0);
         chk({p, " out_index zero"}, oi, 0);
      end
   endtask

   task automatic tick();
      bit a [2];
      bit v;
      a[0] = !reset && !abort && ifc0.out_valid && out_ready;
      a[1] = !reset && !abort && ifc3.out_valid && out_ready;
      if (a[0]) begin
         log_addr.push_back(int'(ifc0.rd_addr));
         log_data.push_back(int'(ifc0.out_data));
         log_idx.push_back(int'(ifc0.out_index));
      end
      if (a[1]) acc3++;
      model_step();
      @(posedge clk);
      @(negedge clk);
      cmp(0, ifc0.out_valid, ifc0.busy, ifc0.done, ifc0.rd_addr, ifc0.out_data, ifc0.out_index);
      cmp(1, ifc3.out_valid, ifc3.busy, ifc3.done, ifc3.rd_addr, ifc3.out_data, ifc3.out_index);
      for (int i = 0; i < 2; i++) begin
         v = i == 0 ? ifc0.out_valid : ifc3.out_valid;
         if (a[i]) begin seen[i] = 1; low[i] = 0; end
         if (!m_act[i] || m_done[i]) seen[i] = 0;
         else if (seen[i]) begin
            if (v) begin
               gap_n[i]++;
               gap_last[i] = low[i];
               if (low[i] != gexp[i]) gap_bad[i]++;
               seen[i] = 0;
            end else low[i]++;
         end
      end
   endtask

   task automatic run_idle(input int budget);
      int c = 0;
      while ((m_act[0] || m_act[1]) && c < budget) begin
         tick();
         c++;
      end
      chk("readout finished within budget", {31'd0, ifc0.busy | ifc3.busy}, 0);
   endtask

   task automatic pulse_start(input int h, input int c);
      head = addr_t'(h);
      count = ord_t'(c);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_data.delete(); log_idx.delete();
      acc3 = 0;
      for (int i = 0; i < 2; i++) begin gap_n[i] = 0; gap_bad[i] = 0; end
   endtask

   // Preload is mem[i] = i+1, so word j from oldest address a0 is ((a0+j)%8)+1.
   task automatic check_log(input int exp_n, input int a0);
      chk("log length", log_data.size(), exp_n);
      for (int j = 0; j < exp_n && j < log_data.size(); j++) begin
         chk($sformatf("log data %0d", j), log_data[j], (a0 + j) % 8 + 1);
         chk($sformatf("log index %0d", j), log_idx[j], j);
      end
   endtask

   task automatic wait_u0_index(input int idx);
      int c = 0;
      while (!(ifc0.out_valid && int'(ifc0.out_index) == idx) && c < 60) begin
         tick();
         c++;
      end
      chk($sformatf("u0 reached index %0d", idx), {31'd0, ifc0.out_valid}, 1);
   endtask

   int ea [5] = '{6, 7, 0, 1, 2};
   int ed [5] = '{7, 8, 1, 2, 3};

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = data_t'(i + 1);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("reset u0 busy", {31'd0, ifc0.busy}, 0);
      chk("reset u3 out_valid", {31'd0, ifc3.out_valid}, 0);
      chk("reset u0 rd_addr", {29'd0, ifc0.rd_addr}, 0);

      // Full log, back-to-back and with dwell
      out_ready = 1'b1;
      clear_logs();
      pulse_start(0, 8);
      run_idle(200);
      check_log(8, 0);
      chk("u0 gaps counted", gap_n[0], 7);
      chk("u0 gap length", gap_last[0], 1);
      chk("u0 gap errors", gap_bad[0], 0);
      chk("u3 gaps counted", gap_n[1], 7);
      chk("u3 gap length", gap_last[1], 4);
      chk("u3 gap errors", gap_bad[1], 0);

      // Wrapping readout
      clear_logs();
      pulse_start(3, 5);
      chk("wrap valid after start edge", {31'd0, ifc0.out_valid}, 0);
      chk("wrap busy after start edge", {31'd0, ifc0.busy}, 1);
      tick();
      chk("wrap first valid", {31'd0, ifc0.out_valid}, 1);
      chk("wrap first rd_addr", {29'd0, ifc0.rd_addr}, 6);
      chk("wrap first data", {16'd0, ifc0.out_data}, 7);
      run_idle(200);
      chk("wrap log length", log_addr.size(), 5);
      for (int j = 0; j < 5 && j < log_addr.size(); j++) begin
         chk($sformatf("wrap addr %0d", j), log_addr[j], ea[j]);
         chk($sformatf("wrap data %0d", j), log_data[j], ed[j]);
      end

      // Empty log
      pulse_start(0, 0);
      chk("empty done", {31'd0, ifc0.done}, 1);
      chk("empty busy", {31'd0, ifc0.busy}, 1);
      tick();
      chk("empty done cleared", {31'd0, ifc0.done}, 0);
      chk("empty busy cleared", {31'd0, ifc0.busy}, 0);

      // Back-pressure on word 2
      clear_logs();
      pulse_start(0, 8);
      wait_u0_index(2);
      out_ready = 1'b0;
      repeat (4) begin
         tick();
         chk("stall valid", {31'd0, ifc0.out_valid}, 1);
         chk("stall data", {16'd0, ifc0.out_data}, 3);
         chk("stall index", {29'd0, ifc0.out_index}, 2);
      end
      out_ready = 1'b1;
      run_idle(200);
      check_log(8, 0);

      // Abort during word 4, then restart from oldest
      pulse_start(0, 8);
      wait_u0_index(4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort valid", {31'd0, ifc0.out_valid}, 0);
      chk("abort busy", {31'd0, ifc0.busy}, 0);
      chk("abort done", {31'd0, ifc0.done}, 0);
      chk("abort data", {16'd0, ifc0.out_data}, 0);
      clear_logs();
      pulse_start(0, 8);
      run_idle(200);
      check_log(8, 0);

      // Reset while u3 dwells
      clear_logs();
      pulse_start(2, 6);
      begin
         int c = 0;
         while (!(acc3 >= 1 && !ifc3.out_valid && ifc3.busy) && c < 60) begin
            tick();
            c++;
         end
      end
      chk("u3 in dwell", {31'd0, ifc3.busy & ~ifc3.out_valid}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset u3 busy", {31'd0, ifc3.busy}, 0);
      chk("reset u3 rd_addr", {29'd0, ifc3.rd_addr}, 0);
      chk("reset u3 data", {16'd0, ifc3.out_data}, 0);
      clear_logs();
      pulse_start(0, 8);
      run_idle(200);
      check_log(8, 0);

      // Randomized traffic
      for (int it = 0; it < 3000; it++) begin
         if (!m_act[0] && !m_act[1] && $urandom_range(7) == 0)
            for (int i = 0; i < 8; i++) mem[i] = data_t'($urandom);
         start     = $urandom_range(3) == 0;
         abort     = $urandom_range(39) == 0;
         reset     = $urandom_range(199) == 0;
         out_ready = $urandom_range(9) < 7;
         head      = addr_t'($urandom);
         count     = ord_t'($urandom);
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      out_ready = 1'b1;
      run_idle(200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
